// File: rtl/sys_defs.sv
// Shared rename definitions: default sizes, tag typedefs, checkpoint record.
// No ports; imported by the rename map and the checkpoint allocator.
package sys_defs;

    localparam int SYS_N         = 2;
    localparam int SYS_ARCH_REGS = 32;
    localparam int SYS_PHYS_REGS = 64;
    localparam int SYS_CKPTS     = 4;

    localparam int SYS_AW = $clog2(SYS_ARCH_REGS);
    localparam int SYS_PW = $clog2(SYS_PHYS_REGS);
    localparam int SYS_CW = $clog2(SYS_CKPTS);
    localparam int SYS_NW = $clog2(SYS_N + 1);

    typedef logic [SYS_AW-1:0] areg_t;
    typedef logic [SYS_PW-1:0] ptag_t;
    typedef logic [SYS_CW-1:0] ckid_t;

    typedef ptag_t [SYS_ARCH_REGS-1:0] map_t;

    // mask: checkpoints that were live when this one was taken
    typedef struct packed {
        map_t                 map;
        logic [SYS_CKPTS-1:0] mask;
        logic                 valid;
    } ckpt_t;

    function automatic map_t identity_map();
        map_t m;
        for (int i = 0; i < SYS_ARCH_REGS; i++) begin
            m[i] = ptag_t'(i);
        end
        return m;
    endfunction

endpackage

// File: rtl/ckpt_alloc.sv
// Picks the N lowest-index free checkpoints, lowest first.
// Ports: i_free (free bitmap), o_id (N packed ids), o_valid (id k exists).
module ckpt_alloc
    import sys_defs::*;
#(
    parameter int CKPTS = SYS_CKPTS,
    parameter int N     = SYS_N,
    localparam int CW   = $clog2(CKPTS)
) (
    input  logic [CKPTS-1:0] i_free,
    output logic [N*CW-1:0]  o_id,
    output logic [N-1:0]     o_valid
);

    always_comb begin
        logic [CKPTS-1:0] avail;
        logic [CW-1:0]    pick;
        logic             found;
        avail   = i_free;
        o_id    = '0;
        o_valid = '0;
        for (int k = 0; k < N; k++) begin
            pick  = '0;
            found = 1'b0;
            // scan downward so the lowest free index wins
            for (int c = CKPTS - 1; c >= 0; c--) begin
                if (avail[c]) begin
                    pick  = CW'(c);
                    found = 1'b1;
                end
            end
            if (found) begin
                avail[pick] = 1'b0;
            end
            o_id[k*CW +: CW] = pick;
            o_valid[k]       = found;
        end
    end

endmodule

// File: rtl/rename_map_ckpt.sv
// Register rename map with branch checkpoints, N lanes per cycle, 1-cycle output.
// Ports: in_* rename group + accepted; out_* registered group with valid/ready;
// resolve_* frees (correct) or restores from (mispredict) a checkpoint.
// Map and checkpoint storage are sized by the sys_defs defaults.
module rename_map_ckpt
    import sys_defs::*;
#(
    parameter int N         = SYS_N,
    parameter int ARCH_REGS = SYS_ARCH_REGS,
    parameter int PHYS_REGS = SYS_PHYS_REGS,
    parameter int CKPTS     = SYS_CKPTS,
    localparam int AW       = $clog2(ARCH_REGS),
    localparam int PW       = $clog2(PHYS_REGS),
    localparam int CW       = $clog2(CKPTS),
    localparam int NW       = $clog2(N + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NW-1:0]   in_count,
    input  logic [N*AW-1:0] in_src1,
    input  logic [N*AW-1:0] in_src2,
    input  logic [N*AW-1:0] in_dest,
    input  logic [N-1:0]    in_has_dest,
    input  logic [N-1:0]    in_is_branch,
    input  logic [N*PW-1:0] free_regs,
    output logic [NW-1:0]   accepted,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NW-1:0]   out_count,
    output logic [N*PW-1:0] out_src1,
    output logic [N*PW-1:0] out_src2,
    output logic [N*PW-1:0] out_told,
    output logic [N*PW-1:0] out_tnew,
    output logic [N*CW-1:0] out_ckpt_id,
    output logic [N-1:0]    out_ckpt_valid,
    input  logic            resolve_valid,
    input  logic [CW-1:0]   resolve_id,
    input  logic            resolve_mispredict
);

    map_t  r_map;
    ckpt_t r_ckpt [CKPTS];

    logic            r_out_valid;
    logic [NW-1:0]   r_out_count;
    logic [N*PW-1:0] r_out_src1;
    logic [N*PW-1:0] r_out_src2;
    logic [N*PW-1:0] r_out_told;
    logic [N*PW-1:0] r_out_tnew;
    logic [N*CW-1:0] r_out_ckpt_id;
    logic [N-1:0]    r_out_ckpt_valid;

    logic [CKPTS-1:0] w_live;
    logic [CKPTS-1:0] w_free;
    logic [CKPTS-1:0] w_rel_oh;
    logic             w_res_hit;
    logic             w_mispred;
    logic             w_release;
    logic             w_take;

    logic [N*CW-1:0]  w_alloc_id;
    logic [N-1:0]     w_alloc_vld;

    logic [NW-1:0]    w_acc;
    map_t             w_next_map;
    logic [N*PW-1:0]  w_src1;
    logic [N*PW-1:0]  w_src2;
    logic [N*PW-1:0]  w_told;
    logic [N*PW-1:0]  w_tnew;
    logic [N*CW-1:0]  w_ck_id;
    logic [N-1:0]     w_ck_vld;
    map_t             w_snap  [N];
    logic [CKPTS-1:0] w_lmask [N];

    always_comb begin
        for (int c = 0; c < CKPTS; c++) begin
            w_live[c] = r_ckpt[c].valid;
        end
    end

    assign w_free    = ~w_live;
    assign w_res_hit = resolve_valid && w_live[resolve_id];
    assign w_mispred = w_res_hit && resolve_mispredict;
    assign w_release = w_res_hit && !resolve_mispredict;
    assign w_rel_oh  = w_release ? (CKPTS'(1) << resolve_id) : '0;
    assign w_take    = reset && (!r_out_valid || out_ready) && !w_mispred;

    // freed checkpoints stay live until the edge, so they are not reused early
    ckpt_alloc #(
        .CKPTS (CKPTS),
        .N     (N)
    ) u_alloc (
        .i_free  (w_free),
        .o_id    (w_alloc_id),
        .o_valid (w_alloc_vld)
    );

    always_comb begin
        map_t             m;
        logic             stop;
        logic [N-1:0]     avl;
        logic [N*CW-1:0]  aid;
        logic [CKPTS-1:0] grp;
        areg_t            a1;
        areg_t            a2;
        areg_t            d;
        ptag_t            fr;
        m        = r_map;
        stop     = !w_take;
        avl      = w_alloc_vld;
        aid      = w_alloc_id;
        grp      = '0;
        w_acc    = '0;
        w_src1   = '0;
        w_src2   = '0;
        w_told   = '0;
        w_tnew   = '0;
        w_ck_id  = '0;
        w_ck_vld = '0;
        for (int i = 0; i < N; i++) begin
            w_snap[i]  = '0;
            w_lmask[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            a1 = in_src1[i*AW +: AW];
            a2 = in_src2[i*AW +: AW];
            d  = in_dest[i*AW +: AW];
            fr = free_regs[i*PW +: PW];
            if (!stop && NW'(i) < in_count) begin
                if (in_is_branch[i] && !avl[0]) begin
                    // younger lanes wait for a checkpoint
                    stop = 1'b1;
                end else begin
                    w_src1[i*PW +: PW] = m[a1];
                    w_src2[i*PW +: PW] = m[a2];
                    w_told[i*PW +: PW] = m[d];
                    w_tnew[i*PW +: PW] = m[d];
                    if (in_has_dest[i] && d != '0) begin
                        m[d]               = fr;
                        w_tnew[i*PW +: PW] = fr;
                    end
                    if (in_is_branch[i]) begin
                        w_ck_vld[i]         = 1'b1;
                        w_ck_id[i*CW +: CW] = aid[CW-1:0];
                        w_snap[i]           = m;
                        w_lmask[i]          = (w_live & ~w_rel_oh) | grp;
                        grp[aid[CW-1:0]]    = 1'b1;
                        avl                 = avl >> 1;
                        aid                 = aid >> CW;
                    end
                    w_acc = NW'(i + 1);
                end
            end
        end
        w_next_map = m;
    end

    assign accepted = w_acc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_map <= identity_map();
            for (int c = 0; c < CKPTS; c++) begin
                r_ckpt[c] <= '0;
            end
            r_out_valid      <= 1'b0;
            r_out_count      <= '0;
            r_out_src1       <= '0;
            r_out_src2       <= '0;
            r_out_told       <= '0;
            r_out_tnew       <= '0;
            r_out_ckpt_id    <= '0;
            r_out_ckpt_valid <= '0;
        end else if (w_mispred) begin
            r_map <= r_ckpt[resolve_id].map;
            // drop the resolved checkpoint and every younger dependent
            for (int c = 0; c < CKPTS; c++) begin
                if (CW'(c) == resolve_id || r_ckpt[c].mask[resolve_id]) begin
                    r_ckpt[c] <= '0;
                end
            end
            r_out_valid <= 1'b0;
        end else begin
            if (w_release) begin
                for (int c = 0; c < CKPTS; c++) begin
                    r_ckpt[c].mask[resolve_id] <= 1'b0;
                end
                r_ckpt[resolve_id].valid <= 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (w_ck_vld[i]) begin
                    r_ckpt[w_ck_id[i*CW +: CW]] <= '{
                        map:   w_snap[i],
                        mask:  w_lmask[i],
                        valid: 1'b1
                    };
                end
            end
            if (w_acc != '0) begin
                r_map            <= w_next_map;
                r_out_valid      <= 1'b1;
                r_out_count      <= w_acc;
                r_out_src1       <= w_src1;
                r_out_src2       <= w_src2;
                r_out_told       <= w_told;
                r_out_tnew       <= w_tnew;
                r_out_ckpt_id    <= w_ck_id;
                r_out_ckpt_valid <= w_ck_vld;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign out_count      = r_out_count;
    assign out_src1       = r_out_src1;
    assign out_src2       = r_out_src2;
    assign out_told       = r_out_told;
    assign out_tnew       = r_out_tnew;
    assign out_ckpt_id    = r_out_ckpt_id;
    assign out_ckpt_valid = r_out_ckpt_valid;

endmodule
